// File: rtl/stage_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_if_pkg
// Description : Shared constants and types for the instruction-fetch stage.
//               Default address/instruction widths, the sequential PC
//               increment and the prefetch queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_if_pkg;

    localparam int          DEF_AW = 32;
    localparam int          DEF_DW = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    // One prefetch queue entry at the default widths.
    typedef struct packed {
        logic [DEF_AW-1:0] pc;
        logic [DEF_DW-1:0] inst;
    } if_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_fifo
// Description : DEPTH-entry synchronous FIFO of {pc, inst} pairs used as the
//               fetch stage prefetch queue. Supports push, pop and clear in
//               the same cycle; clear wins over push/pop.
// Ports       : clk        - clock
//               clrn       - synchronous active-low reset
//               clear      - drop all entries
//               push       - write push_pc/push_inst at the tail
//               pop        - drop the head entry (only when count != 0)
//               count      - number of stored entries, 0..DEPTH
//               head_pc    - pc of head entry (undefined when empty)
//               head_inst  - inst of head entry (undefined when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_fifo
    import stage_if_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [AW-1:0]              push_pc,
    input  logic [DW-1:0]              push_inst,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [AW-1:0]              head_pc,
    output logic [DW-1:0]              head_inst
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!clrn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= adv(wr_ptr);
            if (pop)  rd_ptr <= adv(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (clrn && !clear && push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign count     = cnt;
    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/stage_if_pf.sv
`default_nettype none
// ============================================================================
// Module      : stage_if_pf
// Description : Instruction-fetch stage with a prefetch queue and a
//               valid/ready handshake toward ID. At most one memory read is
//               outstanding; a redirect from MEM flushes every younger fetch.
// Ports       : Clk, Clrn            - clock, synchronous active-low reset
//               MEM_PCSrc            - redirect request
//               MEM_Btarg_or_Jtarg   - redirect target (bits [1:0] ignored)
//               IM_Req, IM_Addr      - instruction memory read strobe/address
//               IM_Rdata             - read data, valid the cycle after IM_Req
//               ID_Ready             - ID accepts the head this cycle
//               IFout_Valid/PC/PC4/Inst - queue head toward ID (0 when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module stage_if_pf
    import stage_if_pkg::*;
#(
    parameter int          AW       = DEF_AW,
    parameter int          DW       = DEF_DW,
    parameter int          DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          MEM_PCSrc,
    input  logic [AW-1:0] MEM_Btarg_or_Jtarg,
    output logic          IM_Req,
    output logic [AW-1:0] IM_Addr,
    input  logic [DW-1:0] IM_Rdata,
    input  logic          ID_Ready,
    output logic          IFout_Valid,
    output logic [AW-1:0] IFout_PC,
    output logic [AW-1:0] IFout_PC4,
    output logic [DW-1:0] IFout_Inst
);

    localparam int            CW  = $clog2(DEPTH + 1);
    localparam int            OW  = CW + 1;
    localparam logic [AW-1:0] INC = AW'(PC_INC);

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] head_pc;
    logic [DW-1:0] head_inst;
    logic          valid;
    logic          pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occ_after_pop;

    assign valid = (count != '0);
    assign pop   = valid & ID_Ready;

    // Reserve a slot for every outstanding read so a returning word always
    // fits; counting the same-cycle pop keeps full-rate streaming at DEPTH=2.
    assign occ_after_pop = OW'(count) + OW'(inflight) - OW'(pop);
    assign issue = Clrn & ~MEM_PCSrc & (occ_after_pop < OW'(DEPTH));
    assign push  = inflight & ~MEM_PCSrc;

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else if (MEM_PCSrc) begin
            fetch_pc <= {MEM_Btarg_or_Jtarg[AW-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) fetch_pc <= fetch_pc + INC;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            inflight_pc <= RESET_PC;
        end else if (issue) begin
            inflight_pc <= fetch_pc;
        end
    end

    if_prefetch_fifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .clrn      (Clrn),
        .clear     (MEM_PCSrc),
        .push      (push),
        .push_pc   (inflight_pc),
        .push_inst (IM_Rdata),
        .pop       (pop & ~MEM_PCSrc),
        .count     (count),
        .head_pc   (head_pc),
        .head_inst (head_inst)
    );

    assign IM_Req      = issue;
    assign IM_Addr     = fetch_pc;
    assign IFout_Valid = valid;
    assign IFout_PC    = valid ? head_pc        : '0;
    assign IFout_PC4   = valid ? head_pc + INC  : '0;
    assign IFout_Inst  = valid ? head_inst      : '0;

endmodule
`default_nettype wire

// File: tb/tb_stage_if_pf.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_if_pf
// Description : Self-checking bench for stage_if_pf. A queue-based model of
//               the fetch stage predicts every output each cycle, a golden
//               PC tracker checks the delivered instruction stream, and
//               directed phases pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_if_pf;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        MEM_PCSrc;
    logic [31:0] MEM_Btarg_or_Jtarg;
    logic        IM_Req;
    logic [31:0] IM_Addr;
    logic [31:0] IM_Rdata;
    logic        ID_Ready;
    logic        IFout_Valid;
    logic [31:0] IFout_PC;
    logic [31:0] IFout_PC4;
    logic [31:0] IFout_Inst;

    stage_if_pf #(
        .AW       (32),
        .DW       (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .Clk                (Clk),
        .Clrn               (Clrn),
        .MEM_PCSrc          (MEM_PCSrc),
        .MEM_Btarg_or_Jtarg (MEM_Btarg_or_Jtarg),
        .IM_Req             (IM_Req),
        .IM_Addr            (IM_Addr),
        .IM_Rdata           (IM_Rdata),
        .ID_Ready           (ID_Ready),
        .IFout_Valid        (IFout_Valid),
        .IFout_PC           (IFout_PC),
        .IFout_PC4          (IFout_PC4),
        .IFout_Inst         (IFout_Inst)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_fetch;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_q[$];
    logic [31:0] gold_next;

    // Sampled DUT outputs of the current cycle
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_pc4, s_inst;
    logic        prev_req;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch   = RESET_PC;
        m_infl    = 1'b0;
        m_infl_pc = RESET_PC;
        m_q.delete();
        gold_next = RESET_PC;
    endtask

    // One clock cycle: drive inputs, compare all outputs to the model,
    // then advance the model by the rules for this cycle's inputs.
    task automatic step(input bit c, input bit s, input bit rdy, input logic [31:0] t);
        bit          e_valid, e_pop, e_issue;
        logic [31:0] e_pc;
        @(negedge Clk);
        Clrn               = c;
        MEM_PCSrc          = s;
        ID_Ready           = rdy;
        MEM_Btarg_or_Jtarg = t;
        IM_Rdata           = prev_req ? mem_word(prev_addr) : $urandom;
        #1;
        s_req   = IM_Req;
        s_addr  = IM_Addr;
        s_valid = IFout_Valid;
        s_pc    = IFout_PC;
        s_pc4   = IFout_PC4;
        s_inst  = IFout_Inst;

        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0] : 32'h0;
        e_pop   = e_valid && rdy;
        e_issue = c && !s && ((m_q.size() + int'(m_infl) - int'(e_pop)) < DEPTH);

        chk("im_req",  {31'b0, s_req},   {31'b0, e_issue});
        chk("im_addr", s_addr,           m_fetch);
        chk("valid",   {31'b0, s_valid}, {31'b0, e_valid});
        chk("if_pc",   s_pc,             e_pc);
        chk("if_pc4",  s_pc4,            e_valid ? e_pc + 32'd4 : 32'h0);
        chk("if_inst", s_inst,           e_valid ? mem_word(e_pc) : 32'h0);

        // Accepted instructions must follow the sequential stream that
        // restarts at each reset vector or redirect target.
        if (c && !s && e_pop) begin
            chk("gold_pc", s_pc, gold_next);
            gold_next = gold_next + 32'd4;
        end

        if (!c) begin
            model_reset();
        end else if (s) begin
            m_q.delete();
            m_infl    = 1'b0;
            m_fetch   = {t[31:2], 2'b00};
            gold_next = {t[31:2], 2'b00};
        end else begin
            if (e_pop)  void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = e_issue;
            if (e_issue) begin
                m_infl_pc = m_fetch;
                m_fetch   = m_fetch + 32'd4;
            end
        end
        prev_req  = s_req;
        prev_addr = s_addr;
    endtask

    initial begin
        int n_iss;
        Clrn = 1'b0; MEM_PCSrc = 1'b0; ID_Ready = 1'b1;
        MEM_Btarg_or_Jtarg = '0; IM_Rdata = '0;
        prev_req = 1'b0; prev_addr = '0;
        repeat (2) @(posedge Clk);
        model_reset();

        // Reset held
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("reset_req",   {31'b0, s_req},   32'd0);
        chk("reset_valid", {31'b0, s_valid}, 32'd0);
        chk("reset_addr",  s_addr,           32'h0);
        chk("reset_pc",    s_pc,             32'h0);

        // Streaming from the reset vector
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 1, 0);
            chk("seq_addr", s_addr, 32'(4 * k));
            if (k < 2) begin
                chk("seq_valid_lo", {31'b0, s_valid}, 32'd0);
            end else begin
                chk("seq_pc",   s_pc,   32'(4 * (k - 2)));
                chk("seq_pc4",  s_pc4,  32'(4 * (k - 1)));
                chk("seq_inst", s_inst, ~32'(4 * (k - 2)));
            end
        end

        // Stall with ID not ready: queue fills, then drains without gaps
        step(0, 0, 1, 0);
        n_iss = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 0);
            n_iss += int'(s_req);
            if (k >= 2) chk("stall_head", s_pc, 32'h0);
        end
        chk("stall_issues", 32'(n_iss), 32'd4);
        chk("stall_req",    {31'b0, s_req}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 1, 0);
            chk("drain_valid", {31'b0, s_valid}, 32'd1);
            chk("drain_pc",    s_pc, 32'(4 * k));
            if (k == 0) chk("resume_addr", s_addr, 32'd16);
        end

        // Redirect with three queued entries and one read in flight
        step(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0103);
        chk("redir_req", {31'b0, s_req}, 32'd0);
        step(1, 0, 1, 0);
        chk("redir_addr",   s_addr, 32'h0000_0100);
        chk("redir_req1",   {31'b0, s_req},   32'd1);
        chk("redir_valid1", {31'b0, s_valid}, 32'd0);
        step(1, 0, 1, 0);
        chk("redir_valid2", {31'b0, s_valid}, 32'd0);
        step(1, 0, 1, 0);
        chk("redir_valid3", {31'b0, s_valid}, 32'd1);
        chk("redir_pc",     s_pc, 32'h0000_0100);

        // Wrap at the top of the address space
        step(1, 1, 1, 32'hFFFF_FFF8);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
        step(1, 0, 1, 0);
        chk("wrap_pc1",  s_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4",  s_pc4, 32'h0000_0000);
        step(1, 0, 1, 0);
        chk("wrap_pc2",  s_pc,  32'h0000_0000);

        // One-cycle reset with a full queue
        for (int k = 0; k < 8; k++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("midrst_req", {31'b0, s_req}, 32'd0);
        step(1, 0, 1, 0);
        chk("postrst_valid", {31'b0, s_valid}, 32'd0);
        chk("postrst_req",   {31'b0, s_req},   32'd1);
        chk("postrst_addr",  s_addr, RESET_PC);

        // Random ID back-pressure, redirects and occasional resets
        for (int k = 0; k < 10000; k++) begin
            step(($urandom % 500) != 0, ($urandom % 30) == 0,
                 ($urandom % 4) != 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
